// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin arbiter driving the common data bus from four functional units
//
// Optional feature macro: CDB_PERF_CNT_EN (adds perfConflict_o per-unit lost-arbitration counters)
//
// Ports:
//   clk_i           clock
//   reset_i         asynchronous active-low reset
//   fuValid_i[k]    unit k holds a finished result
//   fuTag_i[k]      ROB tag of unit k's result (tag 0 is illegal on the bus)
//   fuData_i[k]     unit k's 64-bit result
//   fuReady_o       one-hot combinational grant
//   cdbStall_i      ROB cannot accept a writeback; freezes bus and pointer
//   cdbValid_o      bus carries a result
//   cdbTag_o        broadcast ROB tag
//   cdbData_o       {ready bit, result}
//   cdbSrc_o        index of the unit that produced the bus contents
//   tagErr_o        sticky: a tag-0 result was granted
//   perfConflict_o  (CDB_PERF_CNT_EN only) saturating per-unit conflict counters
module cdb_arbiter #(
    parameter int ROBsize    = 32,
    parameter int ROBsizeLog = $clog2(ROBsize + 1)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [3:0]                 fuValid_i,
    input  logic [3:0][ROBsizeLog-1:0] fuTag_i,
    input  logic [3:0][63:0]           fuData_i,
    output logic [3:0]                 fuReady_o,
    input  logic                       cdbStall_i,
    output logic                       cdbValid_o,
    output logic [ROBsizeLog-1:0]      cdbTag_o,
    output logic [64:0]                cdbData_o,
    output logic [1:0]                 cdbSrc_o,
    output logic                       tagErr_o
`ifdef CDB_PERF_CNT_EN
    ,
    output logic [3:0][15:0]           perfConflict_o
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        BCAST = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [1:0]            rr_ptr_q, rr_ptr_d;
    logic [ROBsizeLog-1:0] tag_q, tag_d;
    logic [64:0]           data_q, data_d;
    logic [1:0]            src_q, src_d;
    logic                  err_q, err_d;

    logic [3:0]            win;
    logic [1:0]            win_idx;
    logic                  win_any;
    logic                  xfer;

    // Rotating priority search starting at the round-robin pointer.
    always_comb begin
        win     = 4'b0000;
        win_idx = 2'd0;
        win_any = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] idx;
            idx = rr_ptr_q + 2'(i);
            if (!win_any && fuValid_i[idx]) begin
                win[idx] = 1'b1;
                win_idx  = idx;
                win_any  = 1'b1;
            end
        end
    end

    // Grant is suppressed during reset so no unit drains a result that the bus would drop.
    assign fuReady_o = win & {4{~cdbStall_i & reset_i}};
    assign xfer      = win_any & ~cdbStall_i;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        tag_d    = tag_q;
        data_d   = data_q;
        src_d    = src_q;
        err_d    = err_q;
        if (!cdbStall_i) begin
            if (xfer) begin
                rr_ptr_d = win_idx + 2'd1;
                if (fuTag_i[win_idx] == '0) begin
                    // Drain the unit but keep the bogus result off the bus.
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    state_d = BCAST;
                    tag_d   = fuTag_i[win_idx];
                    data_d  = {1'b1, fuData_i[win_idx]};
                    src_d   = win_idx;
                end
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q  <= IDLE;
            rr_ptr_q <= 2'd0;
            tag_q    <= '0;
            data_q   <= '0;
            src_q    <= 2'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            tag_q    <= tag_d;
            data_q   <= data_d;
            src_q    <= src_d;
            err_q    <= err_d;
        end
    end

    assign cdbValid_o = (state_q == BCAST);
    assign cdbTag_o   = tag_q;
    assign cdbData_o  = data_q;
    assign cdbSrc_o   = src_q;
    assign tagErr_o   = err_q;

`ifdef CDB_PERF_CNT_EN
    logic [3:0][15:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        for (int k = 0; k < 4; k++) begin
            if (!cdbStall_i && fuValid_i[k] && !fuReady_o[k] && perf_q[k] != 16'hFFFF) begin
                perf_d[k] = perf_q[k] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perfConflict_o = perf_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - self-checking bench for cdb_arbiter against a behavioural model
module tb_cdb_arbiter;

    localparam int TW = 6;

    logic                clk_i = 1'b0;
    logic                reset_i;
    logic [3:0]          fu_valid;
    logic [3:0][TW-1:0]  fu_tag;
    logic [3:0][63:0]    fu_data;
    logic [3:0]          fu_ready;
    logic                cdb_stall;
    logic                cdb_valid;
    logic [TW-1:0]       cdb_tag;
    logic [64:0]         cdb_data;
    logic [1:0]          cdb_src;
    logic                tag_err;
`ifdef CDB_PERF_CNT_EN
    logic [3:0][15:0]    perf;
`endif

    cdb_arbiter dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .fuValid_i  (fu_valid),
        .fuTag_i    (fu_tag),
        .fuData_i   (fu_data),
        .fuReady_o  (fu_ready),
        .cdbStall_i (cdb_stall),
        .cdbValid_o (cdb_valid),
        .cdbTag_o   (cdb_tag),
        .cdbData_o  (cdb_data),
        .cdbSrc_o   (cdb_src),
        .tagErr_o   (tag_err)
`ifdef CDB_PERF_CNT_EN
        ,
        .perfConflict_o (perf)
`endif
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // Requester side
    bit          req_valid [4];
    logic [5:0]  req_tag   [4];
    logic [63:0] req_data  [4];
    bit          stall;
    int          last_grant;
    logic [3:0]  last_ready;

    // Reference model of the bus
    int          m_ptr;
    bit          m_valid;
    logic [5:0]  m_tag;
    logic [64:0] m_data;
    int          m_src;
    bit          m_err;
    int          m_perf [4];

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_winner();
        for (int i = 0; i < 4; i++) begin
            int k;
            k = (m_ptr + i) % 4;
            if (req_valid[k]) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_valid = 0; m_tag = 0; m_data = 0; m_src = 0; m_err = 0;
        for (int k = 0; k < 4; k++) m_perf[k] = 0;
    endtask

    task automatic apply_inputs();
        for (int k = 0; k < 4; k++) begin
            fu_valid[k] = req_valid[k];
            fu_tag[k]   = req_tag[k];
            fu_data[k]  = req_data[k];
        end
        cdb_stall = stall;
    endtask

    task automatic check_bus();
        chk("cdbValid", 65'(cdb_valid), 65'(m_valid));
        chk("cdbTag",   65'(cdb_tag),   65'(m_tag));
        chk("cdbData",  cdb_data,       m_data);
        chk("cdbSrc",   65'(cdb_src),   65'(m_src));
        chk("tagErr",   65'(tag_err),   65'(m_err));
`ifdef CDB_PERF_CNT_EN
        for (int k = 0; k < 4; k++) chk("perf", 65'(perf[k]), 65'(m_perf[k]));
`endif
    endtask

    // One clock cycle: drive, check grant, advance model across the edge, check bus.
    task automatic step();
        int g;
        logic [3:0] exp_ready;
        apply_inputs();
        #1;
        g = model_winner();
        exp_ready = (g >= 0 && !stall) ? 4'(1 << g) : 4'b0000;
        chk("fuReady", 65'(fu_ready), 65'(exp_ready));
        last_ready = fu_ready;
        last_grant = stall ? -1 : g;
        if (!stall) begin
            for (int k = 0; k < 4; k++)
                if (req_valid[k] && k != g && m_perf[k] < 16'hFFFF) m_perf[k]++;
            if (g >= 0) begin
                m_ptr = (g + 1) % 4;
                if (req_tag[g] == 0) begin
                    m_valid = 0;
                    m_err   = 1;
                end else begin
                    m_valid = 1;
                    m_tag   = req_tag[g];
                    m_data  = {1'b1, req_data[g]};
                    m_src   = g;
                end
            end else begin
                m_valid = 0;
            end
        end
        @(posedge clk_i);
        #1;
        check_bus();
    endtask

    // Asserted mid-cycle: outputs must clear without a clock edge.
    task automatic do_reset();
        #3;
        reset_i = 1'b0;
        #1;
        model_reset();
        chk("rst_valid", 65'(cdb_valid), 65'(0));
        chk("rst_tag",   65'(cdb_tag),   65'(0));
        chk("rst_data",  cdb_data,       65'(0));
        chk("rst_src",   65'(cdb_src),   65'(0));
        chk("rst_err",   65'(tag_err),   65'(0));
        chk("rst_ready", 65'(fu_ready),  65'(0));
        @(posedge clk_i);
        #1;
        reset_i = 1'b1;
        for (int k = 0; k < 4; k++) req_valid[k] = 0;
        stall = 0;
        apply_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_order [5];
        exp_order = '{0, 1, 2, 3, 0};
        reset_i = 1'b0;
        stall   = 0;
        for (int k = 0; k < 4; k++) begin
            req_valid[k] = 1; req_tag[k] = 6'(k + 1); req_data[k] = 64'(k);
        end
        apply_inputs();
        model_reset();
        #1;
        chk("rst_ready_held", 65'(fu_ready), 65'(0));
        @(posedge clk_i);
        #1;
        check_bus();
        reset_i = 1'b1;
        for (int k = 0; k < 4; k++) req_valid[k] = 0;

        // Single requester on unit 2
        req_valid[2] = 1; req_tag[2] = 6'd5; req_data[2] = 64'hAB;
        step();
        chk("tp1_ready", 65'(last_ready), 65'(4'b0100));
        chk("tp1_tag",   65'(cdb_tag),    65'(5));
        chk("tp1_data",  cdb_data,        {1'b1, 64'hAB});
        chk("tp1_src",   65'(cdb_src),    65'(2));
        req_valid[2] = 0;
        req_valid[0] = 1; req_tag[0] = 6'd9; req_data[0] = 64'h1;
        req_valid[3] = 1; req_tag[3] = 6'd10; req_data[3] = 64'h2;
        step();
        chk("tp1_ptr3", 65'(cdb_src), 65'(3));
        do_reset();

        // All four continuously valid
        for (int k = 0; k < 4; k++) begin
            req_valid[k] = 1; req_tag[k] = 6'(k + 1); req_data[k] = 64'h100 + 64'(k);
        end
        for (int n = 0; n < 5; n++) begin
            step();
            chk("tp2_src",   65'(cdb_src),   65'(exp_order[n]));
            chk("tp2_valid", 65'(cdb_valid), 65'(1));
        end
        do_reset();

        // Stall holds bus; unit 3 wins after the stall
        req_valid[1] = 1; req_tag[1] = 6'd7; req_data[1] = 64'h77;
        step();
        req_valid[1] = 0;
        req_valid[0] = 1; req_tag[0] = 6'd11; req_data[0] = 64'hA0;
        req_valid[3] = 1; req_tag[3] = 6'd13; req_data[3] = 64'hA3;
        stall = 1;
        for (int n = 0; n < 3; n++) begin
            step();
            chk("tp3_ready", 65'(last_ready), 65'(0));
            chk("tp3_tag",   65'(cdb_tag),    65'(7));
            chk("tp3_valid", 65'(cdb_valid),  65'(1));
        end
        stall = 0;
        step();
        chk("tp3_src", 65'(cdb_src), 65'(3));
        do_reset();

        // Tag 0 request
        req_valid[0] = 1; req_tag[0] = 6'd0; req_data[0] = 64'hDEAD;
        step();
        chk("tp4_ready", 65'(last_ready), 65'(4'b0001));
        chk("tp4_valid", 65'(cdb_valid),  65'(0));
        chk("tp4_err",   65'(tag_err),    65'(1));
        req_valid[0] = 0;
        req_valid[2] = 1; req_tag[2] = 6'd3; req_data[2] = 64'h33;
        step();
        req_valid[2] = 0;
        step();
        chk("tp4_sticky", 65'(tag_err), 65'(1));
        do_reset();

        // Two units contending for 10 cycles
        req_valid[0] = 1; req_tag[0] = 6'd1; req_data[0] = 64'h10;
        req_valid[1] = 1; req_tag[1] = 6'd2; req_data[1] = 64'h11;
        for (int n = 0; n < 10; n++) step();
`ifdef CDB_PERF_CNT_EN
        chk("perf0", 65'(perf[0]), 65'(5));
        chk("perf1", 65'(perf[1]), 65'(5));
`endif
        do_reset();

        // Randomized traffic with protocol-abiding requesters
        for (int n = 0; n < 400; n++) begin
            stall = ($urandom_range(0, 3) == 0);
            step();
            for (int k = 0; k < 4; k++) begin
                if (!req_valid[k] || last_grant == k) begin
                    req_valid[k] = ($urandom_range(0, 2) != 0);
                    req_tag[k]   = ($urandom_range(0, 29) == 0) ? 6'd0 : 6'($urandom_range(1, 32));
                    req_data[k]  = {$urandom, $urandom};
                end
            end
            if (n == 200) do_reset();
        end

        // Reset landing during an active broadcast
        req_valid[1] = 1; req_tag[1] = 6'd21; req_data[1] = 64'h5A5A;
        stall = 0;
        step();
        chk("mid_valid", 65'(cdb_valid), 65'(1));
        do_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

- Shares the single common data bus (CDB) between the four functional-unit pipelines fed by the four reservation stations (whichMath 0–3).
- Each cycle, grants at most one finished result using round-robin priority.
- Registers the winner onto the CDB, where the ROB and all reservation stations snoop it by ROB tag.
- Back-pressures losing units through a valid/ready handshake, and freezes the bus while the ROB stalls.

## Interface
Parameters:
- ROBsize, 32: ROB entries.
- ROBsizeLog, $clog2(ROBsize+1): tag width. Tag 0 is reserved for "value in regfile".

Ports:
- clk_i  input  1  clock.
- reset_i  input  1  reset, asynchronous, active-low.
- fuValid_i  input  [3:0]  unit k holds a finished result.
- fuTag_i  input  [3:0][ROBsizeLog-1:0]  ROB tag of the result from unit k.
- fuData_i  input  [3:0][63:0]  result value from unit k.
- fuReady_o  output  [3:0]  one-hot grant, combinational.
- cdbStall_i  input  1  ROB cannot accept a writeback this cycle.
- cdbValid_o  output  1  bus carries a result.
- cdbTag_o  output  [ROBsizeLog-1:0]  broadcast tag.
- cdbData_o  output  [64:0]  bit 64 = 1 (value ready), bits [63:0] = result.
- cdbSrc_o  output  [1:0]  index of the granted unit.
- tagErr_o  output  1  sticky flag: a tag-0 request was seen.

## Operation
- Round-robin pointer rrPtr (2 bits). Search order each cycle: rrPtr, rrPtr+1, rrPtr+2, rrPtr+3, mod 4. First k with fuValid_i[k]=1 wins.
- fuReady_o[k] = win[k] & ~cdbStall_i. At most one bit is set. Zero when no requester is valid.
- Transfer on unit k: fuValid_i[k] & fuReady_o[k] at a rising edge.
  - cdbValid_o <= 1, cdbTag_o <= fuTag_i[k], cdbData_o <= {1'b1, fuData_i[k]}, cdbSrc_o <= k.
  - rrPtr <= k+1 mod 4.
- No transfer and cdbStall_i=0: cdbValid_o <= 0. Tag, data and src hold their previous values.
- cdbStall_i=1: all bus outputs and rrPtr hold, including cdbValid_o. A result already on the bus stays there until the ROB accepts it.
- Requesters hold valid, tag and data stable until their own ready is seen. The arbiter does not buffer losing requests.
- Tag 0 request: it is granted normally so the unit drains. The bus captures cdbValid_o <= 0 instead of the result, and tagErr_o <= 1 (cleared only by reset).
- States: IDLE (cdbValid_o=0) and BCAST (cdbValid_o=1). Transitions:
  - IDLE→BCAST: legal transfer.
  - BCAST→BCAST: stall, or back-to-back transfer.
  - BCAST→IDLE: no transfer and no stall.

## Timing
- Reset values: rrPtr=0, cdbValid_o=0, cdbTag_o=0, cdbData_o=0, cdbSrc_o=0, tagErr_o=0. fuReady_o is 0 while reset is asserted.
- Reset may arrive mid-broadcast. The in-flight result is dropped; the requester must re-present it after reset.
- Latency: a grant at edge t puts the result on the bus from t until the next edge. One result per cycle sustained; no bubble between consecutive grants.
- cdbStall_i is sampled at the same edge as the grant. A stall prevents new grants and holds the bus in the same cycle.
- Fairness: a continuously valid requester is granted within 4 non-stalled cycles.

## Configuration
- CDB_PERF_CNT_EN defined:
  - Adds output perfConflict_o [3:0][15:0].
  - Counter k increments, saturating at 16'hFFFF, every non-stalled cycle in which fuValid_i[k]=1 and fuReady_o[k]=0.
  - All counters reset to 0.
- CDB_PERF_CNT_EN undefined: the port and counters are absent. Behaviour is otherwise identical.

## Test plan
- Reset, then fuValid_i=4'b0100, tag 5, data 64'hAB: fuReady_o=4'b0100 in the same cycle. Next cycle: cdbValid_o=1, cdbTag_o=5, cdbData_o={1,64'hAB}, cdbSrc_o=2, rrPtr=3.
- All four valid continuously with tags 1–4, no stall: grants arrive in order 0,1,2,3,0. cdbValid_o stays high with no gaps.
- Unit 1 broadcasting tag 7 with cdbStall_i=1 for 3 cycles while units 0 and 3 are valid: fuReady_o=0 and the bus holds tag 7 for all 3 cycles. Unit 3 is granted on the first non-stalled cycle (rrPtr=2 after unit 1's grant, so the search order is 2,3,0,1).
- Unit 0 presents tag 0: fuReady_o[0]=1, next cycle cdbValid_o=0, tagErr_o=1. tagErr_o stays 1 after later legal traffic.
- Assert reset_i low asynchronously mid-cycle during a broadcast: all outputs go to their reset values immediately, without waiting for a clock edge.
- With CDB_PERF_CNT_EN defined: units 0 and 1 valid for 10 cycles, no stall → unit 0 is granted in cycles 1,3,5,7,9 and unit 1 in 2,4,6,8,10. Unit 0 holds valid after each grant, so each loses the other 5 cycles: perfConflict_o[0]=5 and perfConflict_o[1]=5.
